// File: rtl/ram2bit_write_sequencer.sv
// Byte-to-pixel write sequencer for the 2-bit frame store: unpacks each accepted
// byte into four 2-bit writes at consecutive, wrapping addresses.
module ram2bit_write_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2048,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            DataIn,
    input  logic                  DataValid,
    output logic                  DataReady,
    input  logic                  FrameStart,
    output logic [1:0]            DataInA,
    output logic [ADDR_WIDTH-1:0] AddressA,
    output logic                  WrA,
    output logic                  ClockEnA,
    output logic                  FrameDone,
    output logic                  Busy
);

    // state | meaning
    // IDLE  | no byte held, ready for a new byte
    // WRITE | issuing the four pairs of the latched byte
    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [7:0]              byte_q, byte_n;
    logic [1:0]              pair, pair_n;
    logic [1:0]              data_q, data_n;
    logic                    wr_q, wr_n;
    logic                    done_q, done_n;
    logic                    busy_q, busy_n;
    logic                    ready_q, ready_n;
    logic                    accept;

    function automatic logic [1:0] pick(input logic [7:0] b, input logic [1:0] k);
        logic [1:0] idx;
        idx = LSB_FIRST ? k : ~k;
        case (idx)
            2'd0:    pick = b[1:0];
            2'd1:    pick = b[3:2];
            2'd2:    pick = b[5:4];
            default: pick = b[7:6];
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] p);
        next_addr = (p == LAST) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // The FrameStart mask is the only input reaching an output; it keeps a byte
    // offered alongside a restart from being handshaken and then dropped.
    assign DataReady = ready_q & ~FrameStart;
    assign accept    = DataValid & DataReady;

    assign DataInA   = data_q;
    assign AddressA  = addr_q;
    assign WrA       = wr_q;
    assign ClockEnA  = wr_q;
    assign FrameDone = done_q;
    assign Busy      = busy_q;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        addr_n  = addr_q;
        byte_n  = byte_q;
        pair_n  = pair;
        data_n  = data_q;
        wr_n    = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        ready_n = ready_q;

        if (FrameStart) begin
            state_n = IDLE;
            ptr_n   = '0;
            pair_n  = '0;
            ready_n = 1'b1;
        end else if (accept) begin
            state_n = WRITE;
            byte_n  = DataIn;
            wr_n    = 1'b1;
            addr_n  = ptr;
            data_n  = pick(DataIn, 2'd0);
            done_n  = (ptr == LAST);
            ptr_n   = next_addr(ptr);
            busy_n  = 1'b1;
            pair_n  = 2'd1;
            ready_n = 1'b0;
        end else if (state == WRITE && pair != 2'd0) begin
            wr_n    = 1'b1;
            addr_n  = ptr;
            data_n  = pick(byte_q, pair);
            done_n  = (ptr == LAST);
            ptr_n   = next_addr(ptr);
            busy_n  = 1'b1;
            pair_n  = pair + 2'd1;
            // Open the handshake during the last pair so the next byte follows with no bubble.
            ready_n = (pair == 2'd3);
        end else begin
            state_n = IDLE;
            ready_n = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ptr     <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            pair    <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            addr_q  <= addr_n;
            byte_q  <= byte_n;
            pair    <= pair_n;
            data_q  <= data_n;
            wr_q    <= wr_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            ready_q <= ready_n;
        end
    end

endmodule

// File: tb/tb_ram2bit_write_sequencer.sv
// Randomised and directed bench for ram2bit_write_sequencer; a queue-based write
// model predicts every cycle for an LSB-first and an MSB-first instance.
module tb_ram2bit_write_sequencer;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    logic          Clock, Reset, DataValid, FrameStart;
    logic [7:0]    DataIn;
    logic          ready_l, wr_l, ce_l, done_l, busy_l;
    logic [1:0]    data_l;
    logic [AW-1:0] addr_l;
    logic          ready_m, wr_m, ce_m, done_m, busy_m;
    logic [1:0]    data_m;
    logic [AW-1:0] addr_m;

    ram2bit_write_sequencer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut_lsb (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DataValid(DataValid),
        .DataReady(ready_l), .FrameStart(FrameStart), .DataInA(data_l), .AddressA(addr_l),
        .WrA(wr_l), .ClockEnA(ce_l), .FrameDone(done_l), .Busy(busy_l));

    ram2bit_write_sequencer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .LSB_FIRST(1'b0)) dut_msb (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DataValid(DataValid),
        .DataReady(ready_m), .FrameStart(FrameStart), .DataInA(data_m), .AddressA(addr_m),
        .WrA(wr_m), .ClockEnA(ce_m), .FrameDone(done_m), .Busy(busy_m));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    // Model: each accepted byte becomes four queued writes; one write leaves per cycle.
    typedef struct { int addr; int dl; int dm; } wr_t;
    wr_t wq[$];
    int  m_ptr = 0;
    bit  m_wr = 0;
    bit  m_base_ready = 0;
    wr_t cur;

    always @(posedge Clock) begin
        if (Reset) begin
            wq.delete();
            m_ptr = 0;
            m_wr = 0;
            m_base_ready = 0;
        end else begin
            if (FrameStart) begin
                wq.delete();
                m_ptr = 0;
                m_wr = 0;
            end else begin
                if (DataValid && m_base_ready) begin
                    for (int k = 0; k < 4; k++) begin
                        wr_t w;
                        w.addr = m_ptr;
                        w.dl   = (int'(DataIn) >> (2 * k)) & 3;
                        w.dm   = (int'(DataIn) >> (6 - 2 * k)) & 3;
                        wq.push_back(w);
                        m_ptr = (m_ptr + 1) % DEPTH;
                    end
                end
                if (wq.size() > 0) begin
                    cur  = wq.pop_front();
                    m_wr = 1;
                end else begin
                    m_wr = 0;
                end
            end
            m_base_ready = (wq.size() == 0);
        end
    end

    always @(negedge Clock) begin
        if (Reset) begin
            check("rst_wr", wr_l, 0);
            check("rst_busy", busy_l, 0);
            check("rst_done", done_l, 0);
            check("rst_ready", ready_l, 0);
            check("rst_wr_msb", wr_m, 0);
        end else begin
            check("wr", wr_l, m_wr);
            check("ce", ce_l, m_wr);
            check("busy", busy_l, m_wr);
            check("done", done_l, (m_wr && cur.addr == DEPTH - 1));
            check("ready", ready_l, (m_base_ready && !FrameStart));
            check("wr_msb", wr_m, m_wr);
            check("ready_msb", ready_m, (m_base_ready && !FrameStart));
            check("done_msb", done_m, (m_wr && cur.addr == DEPTH - 1));
            if (m_wr) begin
                check("addr", addr_l, cur.addr);
                check("data", data_l, cur.dl);
                check("addr_msb", addr_m, cur.addr);
                check("data_msb", data_m, cur.dm);
            end
        end
    end

    typedef struct { int addr; int dl; int dm; int cyc; } log_t;
    log_t log_q[$];
    int   done_cnt = 0;
    int   done_addr = -1;

    always @(negedge Clock) begin
        if (!Reset && wr_l) begin
            log_t e;
            e.addr = int'(addr_l);
            e.dl   = int'(data_l);
            e.dm   = int'(data_m);
            e.cyc  = cyc;
            log_q.push_back(e);
        end
        if (!Reset && done_l) begin
            done_cnt++;
            done_addr = int'(addr_l);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        bit got;
        got = 0;
        DataIn = b;
        DataValid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge Clock);
            got = ready_l;
            tick();
        end
        check("send_accepted", got, 1);
    endtask

    task automatic pulse_fs();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
    endtask

    initial begin
        int exp_d[8];
        int n;
        int fs_cyc;
        bit found;
        bit last_acc;

        Reset = 1'b1;
        DataValid = 1'b0;
        DataIn = 8'h00;
        FrameStart = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        #1 check("ready_before_first_clk", ready_l, 0);
        tick();
        check("ready_after_first_clk", ready_l, 1);

        // Single byte 0xE4
        log_q.delete();
        send(8'hE4);
        DataValid = 1'b0;
        repeat (6) tick();
        check("e4_count", log_q.size(), 4);
        exp_d = '{0, 1, 2, 3, 0, 0, 0, 0};
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("e4_addr", log_q[i].addr, i);
                check("e4_lsb_data", log_q[i].dl, exp_d[i]);
                check("e4_msb_data", log_q[i].dm, 3 - i);
            end
            check("e4_consecutive", log_q[3].cyc - log_q[0].cyc, 3);
        end

        // Back-to-back 0x1B, 0xFF
        pulse_fs();
        log_q.delete();
        send(8'h1B);
        send(8'hFF);
        DataValid = 1'b0;
        repeat (8) tick();
        check("b2b_count", log_q.size(), 8);
        exp_d = '{3, 2, 1, 0, 3, 3, 3, 3};
        if (log_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("b2b_addr", log_q[i].addr, i);
                check("b2b_data", log_q[i].dl, exp_d[i]);
            end
            check("b2b_no_gap", log_q[7].cyc - log_q[0].cyc, 7);
        end

        // Full frame plus one byte
        pulse_fs();
        log_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 513; i++) send(8'h55);
        DataValid = 1'b0;
        repeat (6) tick();
        check("frame_count", log_q.size(), 2052);
        check("frame_done_cnt", done_cnt, 1);
        check("frame_done_addr", done_addr, 2047);
        if (log_q.size() == 2052) begin
            n = 0;
            for (int i = 0; i < 2048; i++) if (log_q[i].dl == 1 && log_q[i].addr == i) n++;
            check("frame_all_01", n, 2048);
            check("frame_wrap_addr", log_q[2048].addr, 0);
        end

        // FrameStart during the second pair of 0xAA at pointer 100
        pulse_fs();
        log_q.delete();
        for (int i = 0; i < 25; i++) send(8'($urandom));
        send(8'hAA);
        DataValid = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (wr_l && addr_l == 11'd101) found = 1;
            else tick();
        end
        check("fs_found_101", found, 1);
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        repeat (4) tick();
        check("fs_count", log_q.size(), 102);
        if (log_q.size() == 102) begin
            check("fs_last_addr", log_q[101].addr, 101);
            check("fs_last_data", log_q[101].dl, 2);
        end
        log_q.delete();
        send(8'h3C);
        DataValid = 1'b0;
        repeat (6) tick();
        check("fs_next_count", log_q.size(), 4);
        if (log_q.size() > 0) check("fs_next_addr", log_q[0].addr, 0);

        // FrameStart together with DataValid from IDLE
        repeat (2) tick();
        log_q.delete();
        FrameStart = 1'b1;
        DataIn = 8'h0F;
        DataValid = 1'b1;
        fs_cyc = cyc;
        #1 check("fs_masks_ready", ready_l, 0);
        tick();
        FrameStart = 1'b0;
        send(8'h0F);
        DataValid = 1'b0;
        repeat (6) tick();
        check("fsv_count", log_q.size(), 4);
        exp_d = '{3, 3, 0, 0, 0, 0, 0, 0};
        if (log_q.size() == 4) begin
            check("fsv_first_cycle", log_q[0].cyc, fs_cyc + 2);
            for (int i = 0; i < 4; i++) begin
                check("fsv_addr", log_q[i].addr, i);
                check("fsv_data", log_q[i].dl, exp_d[i]);
            end
        end

        // Asynchronous reset mid-byte
        send(8'h36);
        DataValid = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        check("arst_wr", wr_l, 0);
        check("arst_busy", busy_l, 0);
        check("arst_done", done_l, 0);
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        log_q.delete();
        send(8'h99);
        DataValid = 1'b0;
        repeat (6) tick();
        check("arst_count", log_q.size(), 4);
        if (log_q.size() > 0) check("arst_first_addr", log_q[0].addr, 0);

        // Random traffic; the source holds its byte until it is accepted
        last_acc = 0;
        for (int i = 0; i < 400; i++) begin
            if (!DataValid || last_acc) begin
                DataValid = ($urandom_range(0, 9) < 7);
                DataIn = 8'($urandom);
            end
            FrameStart = ($urandom_range(0, 19) == 0);
            @(negedge Clock);
            last_acc = DataValid && ready_l;
            tick();
        end
        DataValid = 1'b0;
        FrameStart = 1'b0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
